// File: rtl/wb_spm_multi.sv
`default_nettype none
// ============================================================================
// Module   : wb_spm_multi
// Brief    : Wishbone-attached multi-channel serial-parallel multiplier.
//            Each channel multiplies WIDTH-bit operands one multiplier bit
//            per clock (optionally two's complement) and flags completion
//            with a sticky DONE bit and a maskable interrupt.
// Revision : 1.0 - initial release
// ============================================================================
module wb_spm_multi #(
    parameter int          WIDTH    = 32,
    parameter int          CHANNELS = 2,
    parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [2:0]  irq
);

    localparam int       c_PROD_W = 2 * WIDTH;
    localparam int       c_CNT_W  = $clog2(WIDTH);
    localparam logic [2:0] c_REG_A    = 3'd0;
    localparam logic [2:0] c_REG_B    = 3'd1;
    localparam logic [2:0] c_REG_CTRL = 3'd2;
    localparam logic [2:0] c_REG_PLO  = 3'd3;
    localparam logic [2:0] c_REG_PHI  = 3'd4;

    logic        r_ack;
    logic [31:0] r_dat;
    logic        w_hit;
    logic        w_acc;
    logic        w_wr;
    logic [2:0]  w_ch;
    logic [2:0]  w_reg;
    logic [31:0] w_rd;
    logic [31:0] w_ch_rd [CHANNELS];
    logic [CHANNELS-1:0] w_ch_irq;
    logic        w_unused;

    assign w_hit = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:12] == BASE_ADR[31:12]);
    // A hit is only accepted while no ack is outstanding, forcing an idle
    // cycle between acks; a request held past its ack counts as a new one.
    assign w_acc = w_hit & ~r_ack;
    assign w_wr  = w_acc & wbs_we_i;
    assign w_ch  = wbs_adr_i[7:5];
    assign w_reg = wbs_adr_i[4:2];
    assign w_unused = &{1'b0, wbs_adr_i[11:8], wbs_adr_i[1:0]};

    // Byte-lane merge of new write data into an existing 32-bit value.
    function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [3:0]  sel);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = sel[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        end
        return res;
    endfunction

    generate
        for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
            logic [WIDTH-1:0]    r_a;
            logic [WIDTH-1:0]    r_b;
            logic [WIDTH-1:0]    r_mplr;
            logic [c_PROD_W-1:0] r_mcand;
            logic [c_PROD_W-1:0] r_accum;
            logic [c_PROD_W-1:0] r_prod;
            logic [c_CNT_W-1:0]  r_cnt;
            logic                r_busy;
            logic                r_done;
            logic                r_irq_en;
            logic                r_signed;
            logic                r_wsigned;
            logic                w_sel_ch;
            logic                w_last;
            logic [c_PROD_W-1:0] w_accum_next;
            logic [c_PROD_W-1:0] w_ext_a;
            logic [63:0]         w_prod64;
            logic [31:0]         w_rd_ch;

            assign w_sel_ch = w_wr && (w_ch == 3'(c));
            assign w_last   = (r_cnt == c_CNT_W'(WIDTH - 1));
            // Operand A extended with the SIGNED value carried by the START write.
            assign w_ext_a  = {{WIDTH{wbs_dat_i[4] & r_a[WIDTH-1]}}, r_a};
            assign w_prod64 = 64'(r_prod);

            // Partial-product step: the MSB of a signed multiplier has negative weight.
            always_comb begin
                w_accum_next = r_accum;
                if (r_mplr[0]) begin
                    w_accum_next = (w_last && r_wsigned) ? (r_accum - r_mcand)
                                                         : (r_accum + r_mcand);
                end
            end

            // Channel register file, START handling and bit-serial datapath.
            always_ff @(posedge wb_clk_i) begin
                if (wb_rst_i) begin
                    r_a       <= '0;
                    r_b       <= '0;
                    r_mplr    <= '0;
                    r_mcand   <= '0;
                    r_accum   <= '0;
                    r_prod    <= '0;
                    r_cnt     <= '0;
                    r_busy    <= 1'b0;
                    r_done    <= 1'b0;
                    r_irq_en  <= 1'b0;
                    r_signed  <= 1'b0;
                    r_wsigned <= 1'b0;
                end else begin
                    if (w_sel_ch && (w_reg == c_REG_A) && !r_busy) begin
                        r_a <= WIDTH'(f_merge(32'(r_a), wbs_dat_i, wbs_sel_i));
                    end
                    if (w_sel_ch && (w_reg == c_REG_B) && !r_busy) begin
                        r_b <= WIDTH'(f_merge(32'(r_b), wbs_dat_i, wbs_sel_i));
                    end
                    if (w_sel_ch && (w_reg == c_REG_CTRL) && wbs_sel_i[0]) begin
                        r_irq_en <= wbs_dat_i[3];
                        r_signed <= wbs_dat_i[4];
                        if (wbs_dat_i[2]) begin
                            r_done <= 1'b0;
                        end
                        if (wbs_dat_i[0] && !r_busy) begin
                            r_mcand   <= w_ext_a;
                            r_mplr    <= r_b;
                            r_wsigned <= wbs_dat_i[4];
                            r_accum   <= '0;
                            r_cnt     <= '0;
                            r_busy    <= 1'b1;
                            r_done    <= 1'b0;
                        end
                    end
                    // Compute step placed last so a completing DONE beats a same-cycle clear.
                    if (r_busy) begin
                        r_accum <= w_accum_next;
                        r_mcand <= r_mcand << 1;
                        r_mplr  <= r_mplr >> 1;
                        r_cnt   <= r_cnt + 1'b1;
                        if (w_last) begin
                            r_prod <= w_accum_next;
                            r_busy <= 1'b0;
                            r_done <= 1'b1;
                            r_cnt  <= '0;
                        end
                    end
                end
            end

            // Register read view of this channel.
            always_comb begin
                w_rd_ch = 32'h0;
                case (w_reg)
                    c_REG_A:    w_rd_ch = 32'(r_a);
                    c_REG_B:    w_rd_ch = 32'(r_b);
                    c_REG_CTRL: w_rd_ch = {27'h0, r_signed, r_irq_en, r_done, r_busy, 1'b0};
                    c_REG_PLO:  w_rd_ch = w_prod64[31:0];
                    c_REG_PHI:  w_rd_ch = w_prod64[63:32];
                    default:    w_rd_ch = 32'h0;
                endcase
            end

            assign w_ch_rd[c]  = w_rd_ch;
            assign w_ch_irq[c] = r_done & r_irq_en;
        end
    endgenerate

    // Channel select for read data; absent channels read as zero.
    always_comb begin
        w_rd = 32'h0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (w_ch == 3'(i)) begin
                w_rd = w_ch_rd[i];
            end
        end
    end

    // Registered single-cycle ack with read data valid only in the ack cycle.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_ack <= 1'b0;
            r_dat <= 32'h0;
        end else begin
            r_ack <= w_acc;
            r_dat <= (w_acc && !wbs_we_i) ? w_rd : 32'h0;
        end
    end

    assign wbs_ack_o = r_ack;
    assign wbs_dat_o = r_dat;
    assign irq       = {2'b00, |w_ch_irq};

endmodule
`default_nettype wire

// File: tb/tb_wb_spm_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_spm_multi
// Brief    : Self-checking bench for wb_spm_multi (WIDTH=32, CHANNELS=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_spm_multi;

    localparam int          W    = 32;
    localparam int          NCH  = 2;
    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wbs_cyc_i = 1'b0;
    logic        wbs_stb_i = 1'b0;
    logic        wbs_we_i  = 1'b0;
    logic [3:0]  wbs_sel_i = 4'h0;
    logic [31:0] wbs_adr_i = 32'h0;
    logic [31:0] wbs_dat_i = 32'h0;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic [2:0]  irq;

    int cycle = 0;
    int total = 0;
    int bad   = 0;
    logic [63:0] prev [NCH];

    wb_spm_multi #(.WIDTH(W), .CHANNELS(NCH), .BASE_ADR(BASE)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wbs_cyc_i(wbs_cyc_i),
        .wbs_stb_i(wbs_stb_i),
        .wbs_we_i (wbs_we_i),
        .wbs_sel_i(wbs_sel_i),
        .wbs_adr_i(wbs_adr_i),
        .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o),
        .wbs_dat_o(wbs_dat_o),
        .irq      (irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    function automatic logic [31:0] adr_of(input int ch, input int off);
        return BASE + 32'(ch * 32 + off);
    endfunction

    // Reference product: plain integer multiply, wrapped to 64 bits.
    function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                             input bit sg);
        longint sa, sb;
        if (sg) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'h0, a});
            sb = longint'({32'h0, b});
        end
        return 64'(sa * sb);
    endfunction

    task automatic wb_write(input int ch, input int off, input logic [31:0] d,
                            input logic [3:0] sel);
        bit got = 0;
        wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 1;
        wbs_adr_i = adr_of(ch, off); wbs_dat_i = d; wbs_sel_i = sel;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clk); #1;
            if (wbs_ack_o) got = 1;
        end
        wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0; wbs_sel_i = 0;
        total++;
        if (!got) begin
            bad++;
            $display("FAIL write_ack ch=%0d off=%0h: ack=0 within 8 cycles, required 1", ch, off);
        end
    endtask

    task automatic wb_read(input int ch, input int off, output logic [31:0] d);
        bit got = 0;
        d = 32'hx;
        wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0;
        wbs_adr_i = adr_of(ch, off); wbs_sel_i = 4'hF;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clk); #1;
            if (wbs_ack_o) begin
                got = 1;
                d = wbs_dat_o;
            end
        end
        wbs_cyc_i = 0; wbs_stb_i = 0; wbs_sel_i = 0;
        total++;
        if (!got) begin
            bad++;
            $display("FAIL read_ack ch=%0d off=%0h: ack=0 within 8 cycles, required 1", ch, off);
        end
    endtask

    // Cycles from edge s until irq[0] is seen high (-1 on timeout).
    task automatic wait_irq(input int s, output int d);
        d = -1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (irq[0]) begin
                d = cycle - s;
                return;
            end
        end
    endtask

    task automatic test_reset;
        logic [31:0] v;
        rst = 1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({wbs_ack_o, wbs_dat_o, irq} !== 36'h0) begin
            bad++;
            $display("FAIL reset_outputs: ack=%b dat=%h irq=%b, required all 0", wbs_ack_o, wbs_dat_o, irq);
        end
        rst = 0;
        for (int ch = 0; ch < NCH; ch++) begin
            for (int off = 0; off <= 16; off += 4) begin
                wb_read(ch, off, v);
                total++;
                if (v !== 32'h0) begin
                    bad++;
                    $display("FAIL reset_reg ch=%0d off=%0h: got %h, required 0", ch, off, v);
                end
            end
            prev[ch] = 64'h0;
        end
    endtask

    task automatic test_unsigned_max;
        logic [31:0] v;
        int s, d;
        wb_write(0, 0, 32'hFFFF_FFFF, 4'hF);
        wb_write(0, 4, 32'hFFFF_FFFF, 4'hF);
        wb_write(0, 8, 32'h09, 4'h1);
        s = cycle;
        wb_read(0, 8, v);
        total++;
        if (v !== 32'h0A) begin
            bad++;
            $display("FAIL umax_busy: ctrl=%h, required 0000000a", v);
        end
        wait_irq(s, d);
        total++;
        if (d !== W) begin
            bad++;
            $display("FAIL umax_latency: got %0d cycles, required %0d", d, W);
        end
        wb_read(0, 16, v);
        total++;
        if (v !== 32'hFFFF_FFFE) begin
            bad++;
            $display("FAIL umax_phi: got %h, required fffffffe", v);
        end
        wb_read(0, 12, v);
        total++;
        if (v !== 32'h1) begin
            bad++;
            $display("FAIL umax_plo: got %h, required 00000001", v);
        end
        wb_read(0, 8, v);
        total++;
        if (v !== 32'h0C) begin
            bad++;
            $display("FAIL umax_done: ctrl=%h, required 0000000c", v);
        end
        wb_write(0, 8, 32'h04, 4'h1);
        prev[0] = 64'hFFFF_FFFE_0000_0001;
    endtask

    task automatic test_signed;
        logic [31:0] v;
        int s, d;
        wb_write(1, 0, 32'hFFFF_FFFD, 4'hF);
        wb_write(1, 4, 32'h5, 4'hF);
        for (int pass = 0; pass < 2; pass++) begin
            wb_write(1, 8, (pass == 0) ? 32'h19 : 32'h09, 4'h1);
            s = cycle;
            wait_irq(s, d);
            total++;
            if (d !== W) begin
                bad++;
                $display("FAIL signed_latency pass=%0d: got %0d, required %0d", pass, d, W);
            end
            wb_read(1, 16, v);
            total++;
            if (v !== ((pass == 0) ? 32'hFFFF_FFFF : 32'h4)) begin
                bad++;
                $display("FAIL signed_phi pass=%0d: got %h, required %h", pass, v,
                         (pass == 0) ? 32'hFFFF_FFFF : 32'h4);
            end
            wb_read(1, 12, v);
            total++;
            if (v !== 32'hFFFF_FFF1) begin
                bad++;
                $display("FAIL signed_plo pass=%0d: got %h, required fffffff1", pass, v);
            end
            wb_write(1, 8, 32'h04, 4'h1);
        end
        prev[1] = 64'h4_FFFF_FFF1;
    endtask

    task automatic test_concurrent;
        logic [31:0] a0, b0, a1, b1, v;
        logic [63:0] p0, p1;
        int s1, d;
        a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
        p0 = ref_prod(a0, b0, 0);
        p1 = ref_prod(a1, b1, 0);
        wb_write(0, 0, a0, 4'hF);
        wb_write(0, 4, b0, 4'hF);
        wb_write(1, 0, a1, 4'hF);
        wb_write(1, 4, b1, 4'hF);
        wb_write(0, 8, 32'h01, 4'h1);
        wb_write(1, 8, 32'h09, 4'h1);
        s1 = cycle;
        wb_write(0, 0, ~a0, 4'hF);
        wait_irq(s1, d);
        total++;
        if (d !== W) begin
            bad++;
            $display("FAIL conc_latency_ch1: got %0d, required %0d", d, W);
        end
        wb_read(0, 8, v);
        total++;
        if (v !== 32'h04) begin
            bad++;
            $display("FAIL conc_ch0_done: ctrl=%h, required 00000004", v);
        end
        wb_read(0, 0, v);
        total++;
        if (v !== a0) begin
            bad++;
            $display("FAIL conc_busy_write: A=%h, required %h", v, a0);
        end
        wb_read(0, 12, v);
        total++;
        if (v !== p0[31:0]) begin
            bad++;
            $display("FAIL conc_ch0_plo: got %h, required %h", v, p0[31:0]);
        end
        wb_read(0, 16, v);
        total++;
        if (v !== p0[63:32]) begin
            bad++;
            $display("FAIL conc_ch0_phi: got %h, required %h", v, p0[63:32]);
        end
        wb_read(1, 12, v);
        total++;
        if (v !== p1[31:0]) begin
            bad++;
            $display("FAIL conc_ch1_plo: got %h, required %h", v, p1[31:0]);
        end
        wb_read(1, 16, v);
        total++;
        if (v !== p1[63:32]) begin
            bad++;
            $display("FAIL conc_ch1_phi: got %h, required %h", v, p1[63:32]);
        end
        wb_write(0, 8, 32'h04, 4'h1);
        wb_write(1, 8, 32'h04, 4'h1);
        prev[0] = p0;
        prev[1] = p1;
    endtask

    task automatic test_irq;
        logic [31:0] v;
        int s, d;
        wb_write(0, 0, 32'd7, 4'hF);
        wb_write(0, 4, 32'd9, 4'hF);
        for (int pass = 0; pass < 2; pass++) begin
            wb_write(0, 8, 32'h09, 4'h1);
            s = cycle;
            wait_irq(s, d);
            total++;
            if (d !== W) begin
                bad++;
                $display("FAIL irq_rise pass=%0d: got %0d cycles, required %0d", pass, d, W);
            end
            wb_read(0, 12, v);
            total++;
            if (v !== 32'd63) begin
                bad++;
                $display("FAIL irq_plo pass=%0d: got %h, required 0000003f", pass, v);
            end
            // First pass clears DONE keeping IRQ_EN; second clears IRQ_EN keeping DONE.
            wb_write(0, 8, (pass == 0) ? 32'h0C : 32'h00, 4'h1);
            total++;
            if (irq !== 3'b000) begin
                bad++;
                $display("FAIL irq_fall pass=%0d: irq=%b, required 000", pass, irq);
            end
            wb_read(0, 8, v);
            total++;
            if (v !== ((pass == 0) ? 32'h08 : 32'h04)) begin
                bad++;
                $display("FAIL irq_ctrl pass=%0d: ctrl=%h, required %h", pass, v,
                         (pass == 0) ? 32'h08 : 32'h04);
            end
        end
        wb_write(0, 8, 32'h04, 4'h1);
        prev[0] = 64'd63;
        wb_write(NCH, 0, 32'hDEAD_BEEF, 4'hF);
        wb_read(0, 0, v);
        total++;
        if (v !== 32'd7) begin
            bad++;
            $display("FAIL bad_channel_alias: ch0 A=%h, required 00000007", v);
        end
        wb_read(NCH, 0, v);
        total++;
        if (v !== 32'h0) begin
            bad++;
            $display("FAIL bad_channel_read: got %h, required 0", v);
        end
        wb_read(0, 20, v);
        total++;
        if (v !== 32'h0) begin
            bad++;
            $display("FAIL bad_offset_read: got %h, required 0", v);
        end
    endtask

    task automatic test_sel;
        logic [31:0] v;
        wb_write(0, 0, 32'h0, 4'hF);
        wb_write(0, 0, 32'h1234_5678, 4'b0101);
        wb_read(0, 0, v);
        total++;
        if (v !== 32'h0034_0078) begin
            bad++;
            $display("FAIL sel_a: got %h, required 00340078", v);
        end
        @(posedge clk); #1;
        total++;
        if (wbs_dat_o !== 32'h0) begin
            bad++;
            $display("FAIL dat_idle: dat_o=%h, required 0", wbs_dat_o);
        end
        wb_write(1, 4, 32'h0, 4'hF);
        wb_write(1, 4, 32'h1234_5678, 4'b1010);
        wb_read(1, 4, v);
        total++;
        if (v !== 32'h1200_5600) begin
            bad++;
            $display("FAIL sel_b: got %h, required 12005600", v);
        end
    endtask

    task automatic test_random;
        logic [31:0] a, b, v;
        logic [63:0] p;
        bit sg;
        int ch, s, d;
        for (int it = 0; it < 10; it++) begin
            ch = $urandom_range(0, NCH - 1);
            a = $urandom; b = $urandom; sg = 1'($urandom_range(0, 1));
            if (it == 0) begin a = 32'h8000_0000; b = 32'h8000_0000; sg = 1; end
            if (it == 1) begin a = 32'h0; end
            if (it == 2) begin b = 32'h8000_0001; sg = 1; end
            p = ref_prod(a, b, sg);
            wb_write(ch, 0, a, 4'hF);
            wb_write(ch, 4, b, 4'hF);
            wb_write(ch, 8, 32'h09 | (32'(sg) << 4), 4'h1);
            s = cycle;
            wb_read(ch, 12, v);
            total++;
            if (v !== prev[ch][31:0]) begin
                bad++;
                $display("FAIL rnd_hold it=%0d: P_LO=%h during run, required %h", it, v, prev[ch][31:0]);
            end
            wait_irq(s, d);
            total++;
            if (d !== W) begin
                bad++;
                $display("FAIL rnd_latency it=%0d: got %0d, required %0d", it, d, W);
            end
            wb_read(ch, 12, v);
            total++;
            if (v !== p[31:0]) begin
                bad++;
                $display("FAIL rnd_plo it=%0d a=%h b=%h s=%0d: got %h, required %h", it, a, b, sg, v, p[31:0]);
            end
            wb_read(ch, 16, v);
            total++;
            if (v !== p[63:32]) begin
                bad++;
                $display("FAIL rnd_phi it=%0d a=%h b=%h s=%0d: got %h, required %h", it, a, b, sg, v, p[63:32]);
            end
            wb_read(ch, 8, v);
            total++;
            if (v !== (32'h0C | (32'(sg) << 4))) begin
                bad++;
                $display("FAIL rnd_ctrl it=%0d: got %h, required %h", it, v, 32'h0C | (32'(sg) << 4));
            end
            wb_write(ch, 8, 32'h04, 4'h1);
            prev[ch] = p;
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] v;
        int s;
        bit seen = 0;
        wb_write(0, 0, 32'h1357_9BDF, 4'hF);
        wb_write(0, 4, 32'h2468_ACE1, 4'hF);
        wb_write(0, 8, 32'h09, 4'h1);
        s = cycle;
        while (cycle < s + 10) begin
            @(posedge clk); #1;
        end
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (irq !== 3'b000) seen = 1;
        end
        total++;
        if (seen) begin
            bad++;
            $display("FAIL rstmid_irq: irq rose after aborted run, required 0");
        end
        for (int off = 0; off <= 16; off += 4) begin
            wb_read(0, off, v);
            total++;
            if (v !== 32'h0) begin
                bad++;
                $display("FAIL rstmid_reg off=%0h: got %h, required 0", off, v);
            end
        end
    endtask

    initial begin
        test_reset;
        test_unsigned_max;
        test_signed;
        test_concurrent;
        test_irq;
        test_sel;
        test_random;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
